// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit CPU front end: widths, opcodes, and fetch state encoding.
package cpu16_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned PC_STEP = 4;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam logic [3:0]  OP_HALT = 4'b1111;

  typedef enum logic [0:0] {
    FETCH_RUN    = 1'b0,
    FETCH_HALTED = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries between fetch and decode; flush empties it in one cycle.
module fetch_fifo
  import cpu16_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [CNT_W-1:0]   count,
  output fetch_entry_t       head
);

  localparam int unsigned      PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap modulo DEPTH so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && !flush;
  assign do_pop  = pop && (count_q != '0) && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(do_push && (count_q == FULL)))
        else $error("fetch_fifo: push into full queue");
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the PC, issues 1-cycle-latency memory reads under a credit limit,
// buffers {pc, instr} for decode, and handles redirect and halt-on-opcode.
module instr_fetch_queue
  import cpu16_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0,
  parameter int unsigned       PC_STEP  = cpu16_pkg::PC_STEP
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               id_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted
);

  localparam int unsigned       CNT_W      = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [CNT_W:0]    CREDIT     = (CNT_W + 1)'(DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;

  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    credit_used;
  fetch_entry_t      head, resp;
  logic              resp_kill, resp_push, halt_seen, issue, pop;

  // The only read that can be in flight during a redirect or reset is the one returning
  // this cycle, so discarding it combinationally is sufficient.
  assign resp_kill = reset || redirect_valid;
  assign resp_push = inflight_q && !resp_kill;
  assign resp      = '{pc: req_pc_q, instr: imem_rdata};
  assign halt_seen = resp_push && (opcode_of(imem_rdata) == OP_HALT);

  assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
  assign issue = (state_q == FETCH_RUN) && !reset && !redirect_valid && !halt_seen
                 && (credit_used < CREDIT);

  assign pop = if_valid && id_ready && !redirect_valid;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (resp_push),
    .push_data (resp),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (redirect_valid) begin
      pc_d    = redirect_pc & ALIGN_MASK;
      state_d = FETCH_RUN;
    end else begin
      if (issue) begin
        pc_d     = pc_q + STEP;
        req_pc_d = pc_q;
      end
      if (halt_seen) state_d = FETCH_HALTED;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FETCH_RUN;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign if_valid  = (count != '0);
  assign if_instr  = if_valid ? head.instr : '0;
  assign if_pc     = if_valid ? head.pc : '0;
  assign halted    = (state_q == FETCH_HALTED);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: cycle vector table plus scoreboard of issued reads.
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NV    = 21;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halted;

  int checks = 0;
  int errors = 0;
  logic halt_mem = 1'b0;

  always #5 clock = ~clock;

  instr_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (16'h0),
    .PC_STEP  (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] addr);
    if (halt_mem && addr == 16'h0008) return 16'hF000;
    return 16'h4100 + {2'b00, addr[15:2]};
  endfunction

  always @(posedge clock) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  exp_t        sb [$];
  logic        stall_prev = 1'b0;
  logic [15:0] stall_pc, stall_instr;

  always @(negedge clock) begin
    exp_t e;
    if (stall_prev) begin
      chk("stall_valid", 32'(if_valid), 32'd1);
      chk("stall_pc", 32'(if_pc), 32'(stall_pc));
      chk("stall_instr", 32'(if_instr), 32'(stall_instr));
    end
    if (reset || redirect_valid) begin
      chk("req_blocked", 32'(imem_req), 32'd0);
      sb.delete();
    end else begin
      if (if_valid && id_ready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_pc", 32'(if_pc), 32'(e.pc));
          chk("sb_instr", 32'(if_instr), 32'(e.instr));
        end
      end
      if (imem_req) begin
        sb.push_back('{pc: imem_addr, instr: mem_word(imem_addr)});
        chk("credit", 32'(sb.size() <= DEPTH), 32'd1);
      end
    end
    stall_prev  = if_valid && !id_ready && !reset && !redirect_valid;
    stall_pc    = if_pc;
    stall_instr = if_instr;
  end

  typedef struct {
    logic        ready;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] pc;
    logic [15:0] instr;
  } vec_t;

  vec_t vec [NV];

  function automatic vec_t mk(input logic r, input logic q, input logic [15:0] a,
                              input logic v, input logic [15:0] p, input logic [15:0] n);
    vec_t t;
    t.ready = r; t.req = q; t.addr = a; t.valid = v; t.pc = p; t.instr = n;
    return t;
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int late;
    logic [15:0] a;

    vec[0]  = mk(1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    vec[1]  = mk(1'b1, 1'b1, 16'h0004, 1'b0, 16'h0000, 16'h0000);
    vec[2]  = mk(1'b1, 1'b1, 16'h0008, 1'b1, 16'h0000, 16'h4100);
    vec[3]  = mk(1'b1, 1'b1, 16'h000C, 1'b1, 16'h0004, 16'h4101);
    vec[4]  = mk(1'b1, 1'b1, 16'h0010, 1'b1, 16'h0008, 16'h4102);
    vec[5]  = mk(1'b1, 1'b1, 16'h0014, 1'b1, 16'h000C, 16'h4103);
    vec[6]  = mk(1'b0, 1'b1, 16'h0018, 1'b1, 16'h0010, 16'h4104);
    vec[7]  = mk(1'b0, 1'b1, 16'h001C, 1'b1, 16'h0010, 16'h4104);
    for (int i = 8; i < 16; i++)
      vec[i] = mk(1'b0, 1'b0, 16'h0020, 1'b1, 16'h0010, 16'h4104);
    vec[16] = mk(1'b1, 1'b0, 16'h0020, 1'b1, 16'h0010, 16'h4104);
    vec[17] = mk(1'b1, 1'b1, 16'h0020, 1'b1, 16'h0014, 16'h4105);
    vec[18] = mk(1'b1, 1'b1, 16'h0024, 1'b1, 16'h0018, 16'h4106);
    vec[19] = mk(1'b1, 1'b1, 16'h0028, 1'b1, 16'h001C, 16'h4107);
    vec[20] = mk(1'b1, 1'b1, 16'h002C, 1'b1, 16'h0020, 16'h4108);

    reset = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
    next_cycle();
    @(negedge clock);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", 32'(if_instr), 32'd0);
    chk("rst_pc", 32'(if_pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    next_cycle();
    reset = 1'b0;

    // Streaming, 10-cycle stall, and resume.
    for (int i = 0; i < NV; i++) begin
      id_ready = vec[i].ready;
      @(negedge clock);
      chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vec[i].req));
      chk($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vec[i].addr));
      chk($sformatf("v%0d_valid", i), 32'(if_valid), 32'(vec[i].valid));
      if (vec[i].valid) begin
        chk($sformatf("v%0d_pc", i), 32'(if_pc), 32'(vec[i].pc));
        chk($sformatf("v%0d_instr", i), 32'(if_instr), 32'(vec[i].instr));
      end
      next_cycle();
    end

    // Reset mid-stream while a pop is pending.
    reset = 1'b1;
    @(negedge clock);
    chk("mrst_pending_pop", 32'(if_valid && id_ready), 32'd1);
    chk("mrst_req", 32'(imem_req), 32'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    chk("mrst_valid", 32'(if_valid), 32'd0);
    chk("mrst_instr", 32'(if_instr), 32'd0);
    chk("mrst_pc", 32'(if_pc), 32'd0);
    chk("mrst_halted", 32'(halted), 32'd0);
    chk("mrst_addr", 32'(imem_addr), 32'h0000);
    next_cycle();
    @(negedge clock);
    chk("mrst_c1_valid", 32'(if_valid), 32'd0);
    next_cycle();
    @(negedge clock);
    chk("mrst_first_valid", 32'(if_valid), 32'd1);
    chk("mrst_first_pc", 32'(if_pc), 32'h0000);
    next_cycle();

    // Redirect with three buffered entries and one read in flight.
    id_ready = 1'b0; reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    repeat (4) next_cycle();
    redirect_valid = 1'b1; redirect_pc = 16'h0042; id_ready = 1'b1;
    @(negedge clock);
    chk("rd_pre_valid", 32'(if_valid), 32'd1);
    chk("rd_pre_pc", 32'(if_pc), 32'h0000);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clock);
    chk("rd_valid", 32'(if_valid), 32'd0);
    chk("rd_req", 32'(imem_req), 32'd1);
    chk("rd_addr", 32'(imem_addr), 32'h0040);
    next_cycle();
    @(negedge clock);
    chk("rd_c1_valid", 32'(if_valid), 32'd0);
    next_cycle();
    @(negedge clock);
    chk("rd_first_pc", 32'(if_pc), 32'h0040);
    chk("rd_first_instr", 32'(if_instr), 32'h4110);
    next_cycle();

    // HALT opcode returned for PC 8.
    halt_mem = 1'b1; reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    late = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (imem_req && c > 2) late++;
      if (c == 2) chk("halt_req8", 32'(imem_addr), 32'h0008);
      if (c == 3) chk("halt_c3", 32'(halted), 32'd0);
      if (c == 4) begin
        chk("halt_c4", 32'(halted), 32'd1);
        chk("halt_pc", 32'(if_pc), 32'h0008);
        chk("halt_instr", 32'(if_instr), 32'hF000);
      end
      if (c == 9) begin
        chk("halt_drained", 32'(if_valid), 32'd0);
        chk("halt_held", 32'(halted), 32'd1);
      end
      next_cycle();
    end
    chk("halt_no_req", 32'(late), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 16'h0000;
    @(negedge clock);
    next_cycle();
    redirect_valid = 1'b0; halt_mem = 1'b0;
    @(negedge clock);
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_req", 32'(imem_req), 32'd1);
    chk("resume_addr", 32'(imem_addr), 32'h0000);
    next_cycle();

    // PC wrap from FFF8; low address bits of the redirect target are dropped.
    redirect_valid = 1'b1; redirect_pc = 16'hFFFB;
    @(negedge clock);
    next_cycle();
    redirect_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      a = 16'hFFF8 + 16'(4 * k);
      chk($sformatf("wrap%0d_addr", k), 32'(imem_addr), 32'(a));
      if (k >= 2) begin
        a = 16'hFFF8 + 16'(4 * (k - 2));
        chk($sformatf("wrap%0d_pc", k), 32'(if_pc), 32'(a));
      end
      next_cycle();
    end

    repeat (3) next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
